multi_track_sequencer: RTL and testbench
========================================

Name: multi_track_sequencer

Overview:
Parametrised key-sequence recorder/player for the PS2 keyboard sampler. It replaces fixed two-sequence shift-register recording with NUM_TRACKS indexed note buffers of DEPTH entries. Playback is tempo-timed, loop mode is optional, and a per-track clear is provided. It sits between keyboard_tracker key levels and the LEDR/audio note driver, and outputs a binary note code.

Parameters:
NUM_KEYS, 9, number of one-hot key inputs (q..o order, MSB = q)
NUM_TRACKS, 2, number of independent recording buffers
DEPTH, 9, maximum notes per track
STEP_CYCLES, 12500000, clock cycles per playback step (0.25 s at 50 MHz); must be >= 2
Localparams: KEY_W = clog2(NUM_KEYS+1); TRK_W = max(1, clog2(NUM_TRACKS)); CNT_W = clog2(DEPTH+1)

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
keys  in  NUM_KEYS  level key-held vector from keyboard_tracker
rec_en  in  1  record request (level)
play_en  in  1  play request (level)
loop  in  1  playback wraps to slot 0 after last note
clear  in  1  clear selected track (level, acted on in IDLE)
track_sel  in  TRK_W  track for record/play/clear
note_out  out  KEY_W  note code: 0 = silence, k = key index k (q=1 .. o=9)
state  out  2  00 IDLE, 01 RECORD, 10 PLAY
count  out  CNT_W  stored-note count of active track (selected track in IDLE)
full  out  1  count == DEPTH
done  out  1  one-cycle pulse when non-loop playback finishes

Behaviour:
- Key decode (combinational): code = (MSB-first index)+1 if exactly one key bit is set, else 0. Multi-key input is treated as silence.
- Press event: code != 0 and code != previous-cycle code. The previous code is registered and reset to 0.
- Reset values: state IDLE, note_out 0, all track counts 0, done 0, step timer 0, rd_ptr 0, active track 0. Buffer contents are don't-care.
- IDLE: note_out <= code (1-cycle live passthrough).
  - clear=1: count[track_sel] <= 0.
  - Else rec_en=1: go to RECORD, latch active track = track_sel, count[active] <= 0.
  - Else play_en=1: go to PLAY, latch active track, rd_ptr <= 0, timer <= 0.
  - Priority: clear > rec_en > play_en.
- track_sel is sampled only on the IDLE exit cycle. Changes during RECORD or PLAY are ignored.
- RECORD: note_out <= code (live monitor).
  - Each press event with count < DEPTH: buf[active][count] <= code, count++.
  - Press events at count == DEPTH are dropped. full stays 1. No wrap and no overwrite.
  - rec_en=0: return to IDLE next cycle; stored data is retained.
- PLAY, count[active] == 0: note_out <= 0, done pulses, return to IDLE.
- PLAY, count > 0:
  - The cycle after entry, note_out <= buf[active][0].
  - Timer counts 0..STEP_CYCLES-1. At terminal count, rd_ptr++ and note_out <= buf[active][rd_ptr+1].
  - After the last slot (rd_ptr == count-1) expires: if loop=1, rd_ptr <= 0 and playback continues seamlessly (slot 0 is output the next cycle). If loop=0, note_out <= 0, done pulses 1 cycle, state returns to IDLE.
  - loop is sampled at each wrap decision.
  - play_en=0 mid-playback: IDLE next cycle, note_out <= live code, done not asserted.
- rec_en and play_en both high in IDLE: RECORD wins. While in RECORD, play_en is ignored. While in PLAY, rec_en is ignored.
- count/full reflect the active track in RECORD/PLAY and track_sel in IDLE.
- Reset in any state returns to IDLE on the next edge, zeroes all counts and silences note_out. Reset overrides all other inputs.

Test Plan:
- Reset, then keys=9'b001000000 -> note_out=3 one cycle later. keys=9'b101000000 -> note_out=0. state=00, count=0.
- Track 0, rec_en=1, press w,q,e (each held 3 cycles with gaps) -> count=3, buf entries 2,1,3. A held key records only once.
- STEP_CYCLES=4, play_en=1, loop=0 on track 0 -> note_out shows 2,1,3, each for 4 cycles. Then note_out=0, done=1 for one cycle, state=00.
- DEPTH=9: record 11 press events -> count=9, full=1, last two dropped. Play with loop=1 -> slot 8 is followed by slot 0 with no silent gap.
- Record track 1 (two notes) after track 0, then clear track 0 -> track 1 count=2 and plays correctly. Play of track 0 -> immediate done, note_out=0.
- Assert reset mid-PLAY at rd_ptr=1 -> next cycle state=00, note_out=0, all counts 0. Also: rec_en and play_en raised together -> state=01.

Source files
------------

// File: rtl/multi_track_sequencer.sv
// multi_track_sequencer
//   Records key presses into NUM_TRACKS independent note buffers of DEPTH entries
//   and plays a selected buffer back one note per STEP_CYCLES clocks, optionally
//   looping. Sits between the keyboard tracker key levels and the note driver.
//
// Ports:
//   i_clock      system clock
//   i_reset      synchronous, active-high reset
//   i_keys       one-hot key-held levels, MSB = first key (code 1)
//   i_rec_en     record request (level)
//   i_play_en    play request (level)
//   i_loop       playback wraps to slot 0 after the last note
//   i_clear      clear the selected track (acted on in IDLE only)
//   i_track_sel  track used for record/play/clear, sampled on IDLE exit
//   o_note_out   note code, 0 = silence, k = key index k
//   o_state      00 IDLE, 01 RECORD, 10 PLAY
//   o_count      stored-note count of active track (selected track in IDLE)
//   o_full       o_count == DEPTH
//   o_done       one-cycle pulse when non-loop playback finishes
module multi_track_sequencer #(
    parameter int unsigned NUM_KEYS    = 9,
    parameter int unsigned NUM_TRACKS  = 2,
    parameter int unsigned DEPTH       = 9,
    parameter int unsigned STEP_CYCLES = 12500000,
    localparam int unsigned KEY_W = $clog2(NUM_KEYS + 1),
    localparam int unsigned TRK_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [NUM_KEYS-1:0] i_keys,
    input  logic             i_rec_en,
    input  logic             i_play_en,
    input  logic             i_loop,
    input  logic             i_clear,
    input  logic [TRK_W-1:0] i_track_sel,
    output logic [KEY_W-1:0] o_note_out,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_done
);

    localparam int unsigned TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REC  = 2'b01;
    localparam logic [1:0] ST_PLAY = 2'b10;

    logic [1:0]       r_state;
    logic [KEY_W-1:0] r_note;
    logic [KEY_W-1:0] r_prev_code;
    logic [TRK_W-1:0] r_active;
    logic [CNT_W-1:0] r_count [NUM_TRACKS];
    logic [CNT_W-1:0] r_rd_ptr;
    logic [TMR_W-1:0] r_timer;
    logic             r_lead;
    logic             r_done;
    logic [KEY_W-1:0] r_buf [NUM_TRACKS][DEPTH];

    logic [KEY_W-1:0] w_code;
    logic             w_press;
    logic [CNT_W-1:0] w_act_count;
    logic             w_last;
    logic             w_term;
    logic             w_wr;
    logic [CNT_W-1:0] w_next_ptr;
    logic [TRK_W-1:0] w_sel_trk;

    // Exactly one key held gives its MSB-first position + 1; zero or several keys is silence.
    always_comb begin
        logic seen;
        logic multi;
        seen   = 1'b0;
        multi  = 1'b0;
        w_code = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (i_keys[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen   = 1'b1;
                w_code = KEY_W'(NUM_KEYS - i);
            end
        end
        if (multi) begin
            w_code = '0;
        end
    end

    assign w_press     = (w_code != '0) && (w_code != r_prev_code);
    assign w_act_count = r_count[r_active];
    assign w_last      = (r_rd_ptr == w_act_count - 1'b1);
    assign w_term      = (r_timer == TMR_W'(STEP_CYCLES - 1));
    assign w_next_ptr  = r_rd_ptr + 1'b1;
    assign w_wr        = (r_state == ST_REC) && w_press && (w_act_count < CNT_W'(DEPTH));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_note      <= '0;
            r_prev_code <= '0;
            r_active    <= '0;
            r_rd_ptr    <= '0;
            r_timer     <= '0;
            r_lead      <= 1'b0;
            r_done      <= 1'b0;
            for (int t = 0; t < int'(NUM_TRACKS); t++) begin
                r_count[t] <= '0;
            end
        end else begin
            r_prev_code <= w_code;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_note <= w_code;
                    if (i_clear) begin
                        r_count[i_track_sel] <= '0;
                    end else if (i_rec_en) begin
                        r_state              <= ST_REC;
                        r_active             <= i_track_sel;
                        r_count[i_track_sel] <= '0;
                    end else if (i_play_en) begin
                        r_state  <= ST_PLAY;
                        r_active <= i_track_sel;
                        r_rd_ptr <= '0;
                        r_timer  <= '0;
                        r_lead   <= 1'b1;
                    end
                end
                ST_REC: begin
                    r_note <= w_code;
                    if (w_wr) begin
                        r_count[r_active] <= w_act_count + 1'b1;
                    end
                    if (!i_rec_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (w_act_count == '0) begin
                        r_note  <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (!i_play_en) begin
                        r_note  <= w_code;
                        r_state <= ST_IDLE;
                    end else if (r_lead) begin
                        // Load slot 0 without advancing the timer so it is shown for a full step.
                        r_lead <= 1'b0;
                        r_note <= r_buf[r_active][0];
                    end else if (w_term) begin
                        r_timer <= '0;
                        if (w_last) begin
                            if (i_loop) begin
                                r_rd_ptr <= '0;
                                r_note   <= r_buf[r_active][0];
                            end else begin
                                r_note  <= '0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_rd_ptr <= w_next_ptr;
                            r_note   <= r_buf[r_active][w_next_ptr];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Note storage needs no reset; only the counts define valid contents.
    always_ff @(posedge i_clock) begin
        if (w_wr) begin
            r_buf[r_active][w_act_count] <= w_code;
        end
    end

    assign w_sel_trk  = (r_state == ST_IDLE) ? i_track_sel : r_active;
    assign o_count    = r_count[w_sel_trk];
    assign o_full     = (o_count == CNT_W'(DEPTH));
    assign o_note_out = r_note;
    assign o_state    = r_state;
    assign o_done     = r_done;

endmodule

// File: tb/tb_multi_track_sequencer.sv
// Bench for multi_track_sequencer: randomized and directed stimulus; a queue-based
// reference model pushes the expected post-edge outputs, a monitor pops and compares.
module tb_multi_track_sequencer;

    localparam int NK = 9;
    localparam int NT = 2;
    localparam int DP = 9;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys;
    logic          rec;
    logic          play;
    logic          lp;
    logic          clr;
    logic [0:0]    tsel;
    logic [3:0]    note_out;
    logic [1:0]    state;
    logic [3:0]    count;
    logic          full;
    logic          done;

    always #5 clk = ~clk;

    multi_track_sequencer #(
        .NUM_KEYS    (NK),
        .NUM_TRACKS  (NT),
        .DEPTH       (DP),
        .STEP_CYCLES (SC)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_keys      (keys),
        .i_rec_en    (rec),
        .i_play_en   (play),
        .i_loop      (lp),
        .i_clear     (clr),
        .i_track_sel (tsel),
        .o_note_out  (note_out),
        .o_state     (state),
        .o_count     (count),
        .o_full      (full),
        .o_done      (done)
    );

    typedef struct {
        int note;
        int st;
        int done;
        int cnt0;
        int cnt1;
        int active;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: tracks are note lists, playback is a per-cycle schedule list.
    int trk [NT][$];
    int sched[$];
    int m_st     = 0;
    int m_note   = 0;
    int m_done   = 0;
    int m_active = 0;
    int m_prev   = 0;
    int m_fresh  = 0;

    function automatic int decode(logic [NK-1:0] k);
        if ($countones(k) != 1) return 0;
        for (int i = 0; i < NK; i++) begin
            if (k[NK-1-i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_step();
        exp_t e;
        int   code;
        bit   press;
        code   = decode(keys);
        press  = (code != 0) && (code != m_prev);
        m_done = 0;
        if (rst) begin
            m_st = 0; m_note = 0; m_active = 0; m_prev = 0;
            for (int t = 0; t < NT; t++) trk[t].delete();
            sched.delete();
        end else begin
            case (m_st)
                0: begin
                    m_note = code;
                    if (clr) begin
                        trk[tsel].delete();
                    end else if (rec) begin
                        m_st = 1; m_active = int'(tsel); trk[tsel].delete();
                    end else if (play) begin
                        m_st = 2; m_active = int'(tsel); sched.delete(); m_fresh = 1;
                    end
                end
                1: begin
                    m_note = code;
                    if (press && trk[m_active].size() < DP) trk[m_active].push_back(code);
                    if (!rec) m_st = 0;
                end
                default: begin
                    if (trk[m_active].size() == 0) begin
                        m_note = 0; m_done = 1; m_st = 0;
                    end else if (!play) begin
                        m_note = code; m_st = 0;
                    end else begin
                        if (sched.size() == 0 && (m_fresh != 0 || lp)) begin
                            for (int i = 0; i < trk[m_active].size(); i++)
                                repeat (SC) sched.push_back(trk[m_active][i]);
                        end
                        m_fresh = 0;
                        if (sched.size() == 0) begin
                            m_note = 0; m_done = 1; m_st = 0;
                        end else begin
                            m_note = sched.pop_front();
                        end
                    end
                end
            endcase
            m_prev = code;
        end
        e.note   = m_note;
        e.st     = m_st;
        e.done   = m_done;
        e.cnt0   = trk[0].size();
        e.cnt1   = trk[1].size();
        e.active = m_active;
        expq.push_back(e);
    endtask

    task automatic chk(string name, int act, int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            int   idx;
            int   ec;
            e   = expq.pop_front();
            idx = (e.st == 0) ? int'(tsel) : e.active;
            ec  = (idx == 0) ? e.cnt0 : e.cnt1;
            chk("note_out", int'(note_out), e.note);
            chk("state", int'(state), e.st);
            chk("count", int'(count), ec);
            chk("full", int'(full), (ec == DP) ? 1 : 0);
            chk("done", int'(done), e.done);
        end
    end

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(logic [NK-1:0] k, int hold, int gap);
        keys = k;
        repeat (hold) step();
        keys = '0;
        repeat (gap) step();
    endtask

    function automatic logic [NK-1:0] rand_onehot();
        logic [NK-1:0] v;
        v = '0;
        v[$urandom_range(NK - 1, 0)] = 1'b1;
        return v;
    endfunction

    initial begin
        rst = 1'b1; keys = '0; rec = 1'b0; play = 1'b0; lp = 1'b0; clr = 1'b0; tsel = 1'b0;
        step(); step();
        rst = 1'b0;

        // Live decode in IDLE, single key and multi-key.
        keys = 9'b001000000; step();
        keys = 9'b101000000; step();
        keys = '0; step();

        // Record w, q, e on track 0; track_sel changes mid-record are ignored.
        rec = 1'b1; step();
        tsel = 1'b1;
        press_key(9'b010000000, 3, 2);
        press_key(9'b100000000, 3, 2);
        press_key(9'b001000000, 3, 2);
        rec = 1'b0; step();
        tsel = 1'b0; step();

        // Non-loop playback: entry, 3 notes x SC cycles, done.
        play = 1'b1; lp = 1'b0;
        repeat (2 + 3 * SC) step();
        play = 1'b0; step(); step();

        // Overfill track 0 with 11 presses, then loop playback twice round.
        rec = 1'b1; step();
        repeat (11) press_key(rand_onehot(), $urandom_range(3, 1), $urandom_range(2, 1));
        rec = 1'b0; step();
        play = 1'b1; lp = 1'b1;
        repeat (2 * DP * SC + 6) step();
        play = 1'b0; lp = 1'b0; step(); step();

        // Record track 1, clear track 0, play both.
        tsel = 1'b1; rec = 1'b1; step();
        press_key(rand_onehot(), 2, 1);
        press_key(rand_onehot(), 2, 1);
        rec = 1'b0; step();
        tsel = 1'b0; clr = 1'b1; step();
        clr = 1'b0; tsel = 1'b1; play = 1'b1;
        repeat (2 + 2 * SC) step();
        play = 1'b0; step();
        tsel = 1'b0; play = 1'b1; step(); step();
        play = 1'b0; step();

        // Reset in the middle of playback at the second slot.
        rec = 1'b1; step();
        repeat (3) press_key(rand_onehot(), 1, 1);
        rec = 1'b0; step();
        play = 1'b1;
        repeat (2 + SC + 1) step();
        rst = 1'b1; step();
        rst = 1'b0; play = 1'b0; step(); step();

        // Record and play requested together.
        rec = 1'b1; play = 1'b1; step(); step();
        rec = 1'b0; play = 1'b0; step(); step();

        // Random traffic.
        repeat (600) begin
            if ($urandom_range(2, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0:       keys = '0;
                    3:       keys = NK'($urandom);
                    default: keys = rand_onehot();
                endcase
            end
            if ($urandom_range(11, 0) == 0) rec = ~rec;
            if ($urandom_range(9, 0) == 0) play = ~play;
            if ($urandom_range(19, 0) == 0) lp = ~lp;
            if ($urandom_range(9, 0) == 0) tsel = ~tsel;
            clr = ($urandom_range(24, 0) == 0);
            rst = ($urandom_range(249, 0) == 0);
            step();
        end
        rst = 1'b0; rec = 1'b0; play = 1'b0; clr = 1'b0; keys = '0;
        repeat (3) step();

        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
